// File: rtl/dcache_2way.sv
// Two-way set-associative write-back, write-allocate data cache.
// Per-set LRU, hit/miss FSM and access/miss performance counters.
module dcache_2way #(
  parameter int ADDR_W  = 8,
  parameter int INDEX_W = 2,
  parameter int CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [7:0]        writedata,
  output logic [7:0]        readdata,
  output logic              busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_address,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_busywait,
  output logic [CNT_W-1:0]  access_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int SETS  = 2**INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH,
    REFILL
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      data_q  [2][SETS];
  logic [31:0]      data_d  [2][SETS];
  logic [TAG_W-1:0] tag_q   [2][SETS];
  logic [TAG_W-1:0] tag_d   [2][SETS];
  logic [SETS-1:0]  valid_q [2];
  logic [SETS-1:0]  valid_d [2];
  logic [SETS-1:0]  dirty_q [2];
  logic [SETS-1:0]  dirty_d [2];
  logic [SETS-1:0]  lru_q, lru_d;

  logic             victim_q, victim_d;
  logic [31:0]      fill_q, fill_d;
  logic [7:0]       rd_q, rd_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] miss_q, miss_d;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [1:0]         off;
  logic               access;
  logic               hit0, hit1, hit;
  logic               hit_way;
  logic [31:0]        hit_blk;
  logic [7:0]         hit_byte;
  logic               vic;

  assign idx    = address[INDEX_W+1:2];
  assign tag    = address[ADDR_W-1:INDEX_W+2];
  assign off    = address[1:0];
  assign access = read | write;

  assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign hit1    = valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit     = hit0 | hit1;
  assign hit_way = hit1;
  assign hit_blk = hit1 ? data_q[1][idx] : data_q[0][idx];
  assign hit_byte = hit_blk[{off, 3'b000} +: 8];

  // Fill an empty way before evicting; way0 wins ties.
  assign vic = !valid_q[0][idx] ? 1'b0 :
               !valid_q[1][idx] ? 1'b1 : lru_q[idx];

  assign busywait = access && !(state_q == IDLE && hit);
  assign readdata = (read && !write && hit) ? hit_byte : rd_q;

  assign access_count = acc_q;
  assign miss_count   = miss_q;

  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    unique case (state_q)
      WRITEBACK: begin
        mem_write     = 1'b1;
        mem_address   = {tag_q[victim_q][idx], idx};
        mem_writedata = data_q[victim_q][idx];
      end
      FETCH: begin
        mem_read    = 1'b1;
        mem_address = {tag, idx};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    tag_d    = tag_q;
    valid_d  = valid_q;
    dirty_d  = dirty_q;
    lru_d    = lru_q;
    victim_d = victim_q;
    fill_d   = fill_q;
    rd_d     = readdata;
    acc_d    = acc_q;
    miss_d   = miss_q;
    if (reset) begin
      state_d  = IDLE;
      for (int w = 0; w < 2; w++) begin
        valid_d[w] = '0;
        dirty_d[w] = '0;
      end
      lru_d    = '0;
      victim_d = 1'b0;
      fill_d   = '0;
      rd_d     = '0;
      acc_d    = '0;
      miss_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (access && hit) begin
            lru_d[idx] = ~hit_way;
            acc_d      = acc_q + CNT_W'(1);
            if (write) begin
              data_d[hit_way][idx][{off, 3'b000} +: 8] = writedata;
              dirty_d[hit_way][idx] = 1'b1;
            end
          end else if (access) begin
            victim_d = vic;
            miss_d   = miss_q + CNT_W'(1);
            state_d  = dirty_q[vic][idx] ? WRITEBACK : FETCH;
          end
        end
        WRITEBACK: begin
          if (!mem_busywait) state_d = FETCH;
        end
        FETCH: begin
          if (!mem_busywait) begin
            fill_d  = mem_readdata;
            state_d = REFILL;
          end
        end
        REFILL: begin
          data_d[victim_q][idx]  = fill_q;
          tag_d[victim_q][idx]   = tag;
          valid_d[victim_q][idx] = 1'b1;
          dirty_d[victim_q][idx] = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    state_q  <= state_d;
    data_q   <= data_d;
    tag_q    <= tag_d;
    valid_q  <= valid_d;
    dirty_q  <= dirty_d;
    lru_q    <= lru_d;
    victim_q <= victim_d;
    fill_q   <= fill_d;
    rd_q     <= rd_d;
    acc_q    <= acc_d;
    miss_q   <= miss_d;
  end

endmodule

// File: tb/tb_dcache_2way.sv
// Scoreboard bench for dcache_2way: flat memory image model,
// expected loads and memory requests queued at stimulus time.
module tb_dcache_2way;

  localparam int N = 5;

  logic        CLK = 1'b0;
  logic        reset;
  logic        read, write;
  logic [7:0]  address, writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read, mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;
  logic        mem_busywait;
  logic [15:0] access_count, miss_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } mreq_t;

  mreq_t      mq[$];
  logic [7:0] rq[$];

  logic [31:0] mem    [64];
  logic [31:0] shadow [64];
  int          bcnt;
  logic        prev_rd, prev_wr;

  dcache_2way dut (
    .CLK          (CLK),
    .reset        (reset),
    .read         (read),
    .write        (write),
    .address      (address),
    .writedata    (writedata),
    .readdata     (readdata),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait),
    .access_count (access_count),
    .miss_count   (miss_count)
  );

  always #5 CLK = ~CLK;

  assign mem_busywait = (mem_read | mem_write) && (bcnt < N);
  assign mem_readdata = mem[mem_address];

  always @(posedge CLK) begin
    if (reset || !(mem_read | mem_write) || !mem_busywait) bcnt <= 0;
    else bcnt <= bcnt + 1;
    if (!reset && mem_write && !mem_busywait)
      mem[mem_address] <= mem_writedata;
  end

  // Memory-request monitor: each new request pops one expectation.
  always @(negedge CLK) begin
    if ((mem_write && !prev_wr) || (mem_read && !prev_rd)) begin
      checks++;
      if (mq.size() == 0) begin
        errors++;
        $display("FAIL mreq_unexpected: wr=%0b addr=%h, required none",
                 mem_write, mem_address);
      end else begin
        mreq_t e;
        e = mq.pop_front();
        if (mem_write !== e.wr || mem_read !== !e.wr ||
            mem_address !== e.addr ||
            (e.wr && mem_writedata !== e.data)) begin
          errors++;
          $display("FAIL mreq: wr=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                   mem_write, mem_address, mem_writedata,
                   e.wr, e.addr, e.data);
        end
      end
    end
    prev_rd <= mem_read;
    prev_wr <= mem_write;
  end

  task automatic push_req(input bit wr, input logic [5:0] a);
    mreq_t e;
    e.wr   = wr;
    e.addr = a;
    e.data = wr ? shadow[a] : 32'h0;
    mq.push_back(e);
  endtask

  task automatic cpu_op(input bit wr, input logic [7:0] a,
                        input logic [7:0] wd, input int exp_cyc);
    int cyc;
    logic [31:0] blk;
    logic [7:0]  ed;
    blk = shadow[a[7:2]];
    if (wr) begin
      blk[{a[1:0], 3'b000} +: 8] = wd;
      shadow[a[7:2]] = blk;
    end else begin
      rq.push_back(blk[{a[1:0], 3'b000} +: 8]);
    end
    @(negedge CLK);
    read = !wr;
    write = wr;
    address = a;
    writedata = wd;
    #1;
    cyc = 0;
    while (busywait && cyc < 200) begin
      @(negedge CLK);
      #1;
      cyc++;
    end
    checks++;
    if (cyc >= 200) begin
      errors++;
      $display("FAIL timeout: addr=%h busywait still %0b, required 0",
               a, busywait);
    end else if (exp_cyc >= 0 && cyc != exp_cyc) begin
      errors++;
      $display("FAIL stall_cycles: addr=%h got %0d, required %0d",
               a, cyc, exp_cyc);
    end
    if (!wr) begin
      ed = rq.pop_front();
      checks++;
      if (readdata !== ed) begin
        errors++;
        $display("FAIL readdata: addr=%h got %h, required %h",
                 a, readdata, ed);
      end
    end
    @(posedge CLK);
    #1;
    read = 1'b0;
    write = 1'b0;
  endtask

  task automatic check_cnt(input string nm, input int acc, input int mis);
    checks++;
    if (access_count !== 16'(acc) || miss_count !== 16'(mis)) begin
      errors++;
      $display("FAIL %s: acc=%0d miss=%0d, required acc=%0d miss=%0d",
               nm, access_count, miss_count, acc, mis);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    read = 1'b0;
    write = 1'b0;
    address = '0;
    writedata = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    #1;
    checks++;
    if (busywait !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 ||
        mem_address !== 6'h0 || mem_writedata !== 32'h0 ||
        readdata !== 8'h0) begin
      errors++;
      $display("FAIL reset_outputs: bw=%b mr=%b mw=%b ma=%h mwd=%h rd=%h, required all 0",
               busywait, mem_read, mem_write, mem_address,
               mem_writedata, readdata);
    end
    check_cnt("reset_counters", 0, 0);
  endtask

  task automatic test_read_miss;
    push_req(1'b0, 6'h00);
    cpu_op(1'b0, 8'h00, 8'h00, 8);
    check_cnt("read_miss_cnt", 1, 1);
  endtask

  task automatic test_back_to_back;
    cpu_op(1'b0, 8'h03, 8'h00, 0);
    check_cnt("hit_cnt", 2, 1);
  endtask

  task automatic test_write_alloc;
    push_req(1'b0, 6'h04);
    cpu_op(1'b1, 8'h10, 8'hAB, 8);
    check_cnt("write_miss_cnt", 3, 2);
    cpu_op(1'b0, 8'h10, 8'h00, 0);
    check_cnt("write_hit_read_cnt", 4, 2);
  endtask

  task automatic test_clean_evict;
    push_req(1'b0, 6'h08);
    cpu_op(1'b0, 8'h20, 8'h00, 8);
    check_cnt("clean_evict_cnt", 5, 3);
  endtask

  task automatic test_dirty_evict;
    push_req(1'b1, 6'h04);
    push_req(1'b0, 6'h0C);
    cpu_op(1'b0, 8'h30, 8'h00, 2 * (N + 1) + 2);
    check_cnt("dirty_evict_cnt", 6, 4);
    checks++;
    if (mem[4] !== shadow[4]) begin
      errors++;
      $display("FAIL wb_mem: got %h, required %h", mem[4], shadow[4]);
    end
  endtask

  task automatic test_reset_mid_miss;
    int cyc;
    push_req(1'b0, 6'h10);
    @(negedge CLK);
    read = 1'b1;
    address = 8'h40;
    cyc = 0;
    while (!mem_read && cyc < 20) begin
      @(negedge CLK);
      cyc++;
    end
    checks++;
    if (!mem_read) begin
      errors++;
      $display("FAIL mid_miss_fetch: mem_read=%b, required 1", mem_read);
    end
    @(negedge CLK);
    reset = 1'b1;
    read = 1'b0;
    @(posedge CLK);
    #1;
    checks++;
    if (mem_read !== 1'b0 || busywait !== 1'b0) begin
      errors++;
      $display("FAIL abort: mem_read=%b busywait=%b, required 0 0",
               mem_read, busywait);
    end
    check_cnt("abort_counters", 0, 0);
    @(negedge CLK);
    reset = 1'b0;
    push_req(1'b0, 6'h00);
    cpu_op(1'b0, 8'h00, 8'h00, 8);
    check_cnt("post_reset_miss_cnt", 1, 1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]    = 32'h44332211 + 32'(i) * 32'h01010101;
      shadow[i] = mem[i];
    end
    bcnt = 0;
    prev_rd = 1'b0;
    prev_wr = 1'b0;
    test_reset();
    test_read_miss();
    test_back_to_back();
    test_write_alloc();
    test_clean_evict();
    test_dirty_evict();
    test_reset_mid_miss();
    repeat (3) @(negedge CLK);
    checks++;
    if (mq.size() != 0) begin
      errors++;
      $display("FAIL mreq_pending: %0d left, required 0", mq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
